ts_packet_gen: RTL and testbench
================================

TS_PACKET_GEN -- requirements
Module: ts_packet_gen

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 32: width of pkt_count.
REQ-002 The block SHALL have parameter GAP_WIDTH, default 8: width of gap_cfg.
REQ-003 clk  input  1  Single clock for all logic; data is presented and sampled on its rising edge.
REQ-004 rst  input  1  Reset, synchronous and active-high.
REQ-005 enable  input  1  Run request; sampled only at packet boundaries.
REQ-006 pid_cfg  input  13  PID inserted in the header; sampled at packet start.
REQ-007 gap_cfg  input  GAP_WIDTH  Number of idle cycles between packets; sampled at packet end.
REQ-008 ready  input  1  Sink accept; a byte transfers when valid_out and ready are both high.
REQ-009 valid_out  output  1  Byte valid.
REQ-010 sync_out  output  1  High with byte 0 (0x47) of each packet.
REQ-011 ts_data_out  output  8  TS byte.
REQ-012 pkt_count  output  CNT_WIDTH  Number of packets fully transmitted.

Function
REQ-013 The FSM SHALL have states IDLE, HDR (bytes 0-3), PAYLOAD (bytes 4-187) and GAP.
- IDLE->HDR when enable=1.
- HDR->PAYLOAD after byte 3 transfers.
- PAYLOAD->GAP after byte 187 transfers if gap_cfg!=0; otherwise directly to HDR (enable=1) or IDLE (enable=0).
- GAP->HDR or IDLE after gap_cfg cycles, selected by enable.
REQ-014 The latency from enable rising in IDLE to the first beat SHALL be 1 cycle: valid_out=1, sync_out=1, ts_data_out=0x47 in the following cycle.
REQ-015 Header bytes SHALL be:
- byte0 = 0x47.
- byte1 = {TEI=0, PUSI=1, prio=0, pid[12:8]}.
- byte2 = pid[7:0].
- byte3 = {scr=00, afc=01, cc[3:0]}.
REQ-016 Payload byte n (n=4..187) SHALL equal n[7:0].
REQ-017 While ready=0 with valid_out=1, ts_data_out, sync_out and the byte index SHALL hold stable.
REQ-018 valid_out SHALL be 0 in IDLE and in GAP.
REQ-019 The byte index SHALL wrap 187->0 exactly at packet end; every packet SHALL be exactly 188 transferred bytes.
REQ-020 cc SHALL advance by 1 modulo 16 after each completed packet (15->0).
REQ-021 pkt_count SHALL increment on the transfer of byte 187 and wrap at 2^CNT_WIDTH.
REQ-022 Deasserting enable mid-packet SHALL NOT truncate the packet: the packet completes, then the FSM goes to GAP/IDLE.
REQ-023 A change in pid_cfg mid-packet SHALL take effect at the next packet.
REQ-024 A change in gap_cfg SHALL take effect at the next packet end.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL load: state=IDLE, valid_out=0, sync_out=0, ts_data_out=0x00, cc=0, pkt_count=0, byte index=0, gap counter=0.
REQ-026 Reset mid-packet SHALL abort the packet immediately, with no completion and no pkt_count increment.
REQ-027 rst SHALL take priority over all other inputs.

Configuration
REQ-028 When TS_ERR_INJECT_EN is defined, the block SHALL add input err_inject (1 bit).
- A pulse arms a one-shot flag.
- At the next packet end, cc advances by 2 instead of 1 (modulo 16), emulating one lost packet; the flag then clears.
- Pulses while armed are ignored.
REQ-029 When TS_ERR_INJECT_EN is undefined, the err_inject port SHALL be absent and cc SHALL always advance by 1.

Structure
REQ-030 Shared package ts_pkg SHALL hold TS_SYNC_BYTE=8'h47, TS_PKT_LEN=188, TS_HDR_LEN=4 and the FSM state typedef.
REQ-031 The sub-module ts_cc_ctrl SHALL own the cc register, the increment, and the injection flag; all other logic SHALL stay in ts_packet_gen.

Verification
REQ-032 Reset, then enable=1, pid_cfg=0x100, gap_cfg=0, ready=1 -> packet 1 is bytes 47 41 00 10 04 05 .. BB and packet 2 starts with 47 41 00 11 with no idle cycle between them; pkt_count=2 after 376 beats.
REQ-033 Run 17 packets -> cc sequence 0..15,0; pkt_count=17.
REQ-034 ready toggled 1/0 on alternate cycles -> each byte is held while ready=0; the byte sequence is identical to the ready=1 run; packet spans 376 cycles.
REQ-035 gap_cfg=5, then drop enable during byte 50 -> packet completes to byte 187, 5 cycles with valid_out=0, then IDLE with valid_out=0 held.
REQ-036 rst pulsed at byte 100 -> the next cycle has valid_out=0 and pkt_count=0; re-enable -> restart at 47 with cc=0.
REQ-037 With TS_ERR_INJECT_EN defined, pulse err_inject during packet with cc=3 -> next packet has cc=5, the following one cc=6.

Source files
------------

// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared constants, FSM state type and header byte helper for the TS packet generator
package ts_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_PKT_LEN   = 188;
    localparam int         TS_HDR_LEN   = 4;

    // Byte-index values at which the FSM changes phase.
    localparam logic [7:0] TS_LAST_HDR_IDX = 8'(TS_HDR_LEN - 1);
    localparam logic [7:0] TS_LAST_IDX     = 8'(TS_PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } ts_state_e;

    // Header bytes 0..3: sync, {TEI=0,PUSI=1,prio=0,pid_hi}, pid_lo, {scr=00,afc=01,cc}.
    function automatic logic [7:0] ts_hdr_byte(input logic [1:0]  idx,
                                               input logic [12:0] pid,
                                               input logic [3:0]  cc);
        logic [7:0] b;
        case (idx)
            2'd0:    b = TS_SYNC_BYTE;
            2'd1:    b = {3'b010, pid[12:8]};
            2'd2:    b = pid[7:0];
            default: b = {2'b00, 2'b01, cc};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ts_cc_ctrl.sv
// rtl/ts_cc_ctrl.sv - continuity counter register with optional one-shot lost-packet injection
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   advance_i    one-cycle pulse at each completed packet
//   err_inject_i (only with TS_ERR_INJECT_EN) arms a one-shot double advance
//   cc_o         current continuity counter
//
// Build option: TS_ERR_INJECT_EN adds err_inject_i.
module ts_cc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance_i,
`ifdef TS_ERR_INJECT_EN
    input  logic       err_inject_i,
`endif
    output logic [3:0] cc_o
);

    logic [3:0] cc_q, cc_d;

`ifdef TS_ERR_INJECT_EN
    logic armed_q, armed_d;

    always_comb begin
        cc_d    = cc_q;
        armed_d = armed_q;
        if (advance_i) begin
            if (armed_q) begin
                // Skip one value so the sink sees a cc discontinuity.
                cc_d    = cc_q + 4'd2;
                armed_d = 1'b0;
            end else begin
                cc_d = cc_q + 4'd1;
            end
        end
        // Pulses while already armed are dropped.
        if (!armed_q && err_inject_i) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q    <= 4'd0;
            armed_q <= 1'b0;
        end else begin
            cc_q    <= cc_d;
            armed_q <= armed_d;
        end
    end
`else
    always_comb begin
        cc_d = cc_q;
        if (advance_i) begin
            cc_d = cc_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= 4'd0;
        end else begin
            cc_q <= cc_d;
        end
    end
`endif

    assign cc_o = cc_q;

endmodule

// File: rtl/ts_packet_gen.sv
// rtl/ts_packet_gen.sv - MPEG-TS test packet generator (188-byte packets, counting payload)
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   err_inject   (only with TS_ERR_INJECT_EN) arms one skipped cc value
//   enable       run request, sampled at packet boundaries
//   pid_cfg      PID, latched at packet start
//   gap_cfg      idle cycles between packets, sampled at packet end
//   ready        sink accept
//   valid_out    byte valid
//   sync_out     marks byte 0 (0x47)
//   ts_data_out  TS byte
//   pkt_count    completed packet count
//
// Build option: TS_ERR_INJECT_EN adds the err_inject input.
module ts_packet_gen
    import ts_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int GAP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef TS_ERR_INJECT_EN
    input  logic                 err_inject,
`endif
    input  logic                 enable,
    input  logic [12:0]          pid_cfg,
    input  logic [GAP_WIDTH-1:0] gap_cfg,
    input  logic                 ready,
    output logic                 valid_out,
    output logic                 sync_out,
    output logic [7:0]           ts_data_out,
    output logic [CNT_WIDTH-1:0] pkt_count
);

    ts_state_e            state_q, state_d;
    logic [7:0]           idx_q, idx_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [12:0]          pid_q, pid_d;
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic                 pkt_end;
    logic                 xfer;
    logic [3:0]           cc;

    ts_cc_ctrl u_cc (
        .clk          (clk),
        .rst          (rst),
        .advance_i    (pkt_end),
`ifdef TS_ERR_INJECT_EN
        .err_inject_i (err_inject),
`endif
        .cc_o         (cc)
    );

    assign valid_out = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);
    assign xfer      = valid_out && ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        pid_d       = pid_q;
        pkt_count_d = pkt_count_q;
        pkt_end     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_HDR;
                    idx_d   = 8'd0;
                    pid_d   = pid_cfg;
                end
            end

            ST_HDR: begin
                if (xfer) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == TS_LAST_HDR_IDX) begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (xfer) begin
                    if (idx_q == TS_LAST_IDX) begin
                        idx_d       = 8'd0;
                        pkt_end     = 1'b1;
                        pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
                        if (gap_cfg != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_cfg;
                        end else if (enable) begin
                            state_d = ST_HDR;
                            pid_d   = pid_cfg;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end

            ST_GAP: begin
                // The counter was loaded with gap_cfg on entry, so leaving when it
                // reads 1 yields exactly gap_cfg idle cycles.
                if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    gap_cnt_d = '0;
                    if (enable) begin
                        state_d = ST_HDR;
                        pid_d   = pid_cfg;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 8'd0;
            gap_cnt_q   <= '0;
            pid_q       <= 13'd0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            pid_q       <= pid_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Outputs decode straight from registered state, so they hold while ready=0.
    always_comb begin
        ts_data_out = 8'h00;
        sync_out    = 1'b0;
        case (state_q)
            ST_HDR: begin
                ts_data_out = ts_hdr_byte(idx_q[1:0], pid_q, cc);
                sync_out    = (idx_q == 8'd0);
            end
            ST_PAYLOAD: begin
                ts_data_out = idx_q;
            end
            default: begin
                ts_data_out = 8'h00;
            end
        endcase
    end

    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_ts_packet_gen.sv
// tb/tb_ts_packet_gen.sv - self-checking bench for ts_packet_gen
module tb_ts_packet_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ready;
    logic [12:0] pid_cfg;
    logic [7:0]  gap_cfg;
`ifdef TS_ERR_INJECT_EN
    logic        err_inject;
`endif
    logic        valid_out;
    logic        sync_out;
    logic [7:0]  ts_data_out;
    logic [31:0] pkt_count;

    int total = 0;
    int bad   = 0;

    ts_packet_gen dut (
        .clk         (clk),
        .rst         (rst),
`ifdef TS_ERR_INJECT_EN
        .err_inject  (err_inject),
`endif
        .enable      (enable),
        .pid_cfg     (pid_cfg),
        .gap_cfg     (gap_cfg),
        .ready       (ready),
        .valid_out   (valid_out),
        .sync_out    (sync_out),
        .ts_data_out (ts_data_out),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    // Expected byte n of a packet carrying pid and continuity count cc.
    function automatic logic [7:0] ref_byte(input int n, input logic [12:0] pid, input int cc);
        logic [3:0] c;
        c = 4'(cc % 16);
        if (n == 0)      return 8'h47;
        else if (n == 1) return {3'b010, pid[12:8]};
        else if (n == 2) return pid[7:0];
        else if (n == 3) return {4'b0001, c};
        else             return 8'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        enable  = 1'b1;
        ready   = 1'b1;
        pid_cfg = 13'($urandom);
        gap_cfg = 8'd0;
        tick();
        tick();
        total++; if (valid_out !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %0b want 0", valid_out); end
        total++; if (sync_out !== 1'b0)   begin bad++; $display("FAIL reset_sync: got %0b want 0", sync_out); end
        total++; if (ts_data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 00", ts_data_out); end
        total++; if (pkt_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", pkt_count); end
        rst    = 1'b0;
        enable = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int errs;
        int fb_i;
        logic [7:0] fb_act, fb_exp, e;
        errs = 0; fb_i = -1; fb_act = 0; fb_exp = 0;
        do_reset();
        pid_cfg = 13'h100;
        gap_cfg = 8'd0;
        ready   = 1'b1;
        enable  = 1'b1;
        tick();
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL latency_valid: got %0b want 1", valid_out); end
        total++; if (sync_out !== 1'b1)  begin bad++; $display("FAIL latency_sync: got %0b want 1", sync_out); end
        total++; if (ts_data_out !== 8'h47) begin bad++; $display("FAIL latency_data: got %0h want 47", ts_data_out); end
        for (int i = 0; i < 376; i++) begin
            e = ref_byte(i % 188, 13'h100, i / 188);
            if (valid_out !== 1'b1 || ts_data_out !== e || sync_out !== ((i % 188) == 0)) begin
                errs++;
                if (fb_i < 0) begin fb_i = i; fb_act = ts_data_out; fb_exp = e; end
            end
            if (i == 200) enable = 1'b0;
            tick();
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL basic_bytes: %0d bad beats, first at %0d got %0h want %0h", errs, fb_i, fb_act, fb_exp); end
        total++; if (pkt_count !== 32'd2) begin bad++; $display("FAIL basic_count: got %0d want 2", pkt_count); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL basic_idle: got %0b want 0", valid_out); end
    endtask

    task automatic test_cc_wrap_random();
        logic [12:0] pkt_pid [18];
        int          gap_of  [17];
        int          pkt_err [17];
        int          p, n, idle, seen;
        bit          gap_done, r;
        logic [7:0]  e;
        for (int q = 0; q < 17; q++) begin pkt_err[q] = 0; gap_of[q] = 0; end
        do_reset();
        pid_cfg    = 13'($urandom);
        pkt_pid[0] = pid_cfg;
        gap_cfg    = 8'($urandom_range(0, 3));
        enable     = 1'b1;
        p = 0; n = 0; idle = 0; gap_done = 1'b1;
        for (int cyc = 0; cyc < 20000 && p < 17; cyc++) begin
            r = ($urandom_range(0, 3) != 0);
            ready = r;
            if (valid_out === 1'b1) begin
                if (n == 0 && p > 0 && !gap_done) begin
                    gap_done = 1'b1;
                    total++;
                    if (idle !== gap_of[p-1]) begin bad++; $display("FAIL gap_len pkt%0d: got %0d want %0d", p, idle, gap_of[p-1]); end
                end
                e = ref_byte(n, pkt_pid[p], p);
                if (ts_data_out !== e || sync_out !== (n == 0)) pkt_err[p]++;
                if (r) begin
                    if (n == 1) begin
                        pid_cfg      = 13'($urandom);
                        pkt_pid[p+1] = pid_cfg;
                        gap_cfg      = 8'($urandom_range(0, 3));
                        gap_of[p]    = int'(gap_cfg);
                        if (p == 16) enable = 1'b0;
                    end
                    n++;
                    if (n == 188) begin n = 0; p++; idle = 0; gap_done = 1'b0; end
                end
            end else if (p > 0) begin
                idle++;
            end
            tick();
        end
        total++; if (p !== 17) begin bad++; $display("FAIL cc_timeout: got %0d packets want 17", p); end
        for (int q = 0; q < 17; q++) begin
            total++;
            if (pkt_err[q] !== 0) begin bad++; $display("FAIL cc_pkt%0d_bytes: got %0d bad beats want 0", q, pkt_err[q]); end
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (valid_out !== 1'b0) seen++;
            tick();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL cc_stop: got %0d valid cycles want 0", seen); end
        total++; if (pkt_count !== 32'd17) begin bad++; $display("FAIL cc_count: got %0d want 17", pkt_count); end
    endtask

    task automatic test_ready_toggle();
        int errs, hold_errs, n, span;
        bit r, prev_r;
        logic [7:0] prev_d, e;
        errs = 0; hold_errs = 0; n = 0; span = 0; prev_r = 1'b1; prev_d = 0;
        do_reset();
        pid_cfg = 13'h100;
        gap_cfg = 8'd0;
        enable  = 1'b1;
        tick();
        for (int c = 0; c < 800 && n < 188; c++) begin
            r = (c % 2) == 1;
            ready = r;
            if (c == 10) enable = 1'b0;
            e = ref_byte(n, 13'h100, 0);
            if (valid_out !== 1'b1 || ts_data_out !== e || sync_out !== (n == 0)) errs++;
            if (!prev_r && ts_data_out !== prev_d) hold_errs++;
            prev_r = r;
            prev_d = ts_data_out;
            if (r) begin
                n++;
                if (n == 188) span = c + 1;
            end
            tick();
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL toggle_bytes: got %0d bad beats want 0", errs); end
        total++; if (hold_errs !== 0) begin bad++; $display("FAIL toggle_hold: got %0d changes want 0", hold_errs); end
        total++; if (span !== 376) begin bad++; $display("FAIL toggle_span: got %0d want 376", span); end
        total++; if (pkt_count !== 32'd1) begin bad++; $display("FAIL toggle_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_gap_stop();
        int errs, vbad;
        logic [12:0] pid;
        logic [7:0]  e;
        errs = 0; vbad = 0;
        do_reset();
        pid     = 13'($urandom);
        pid_cfg = pid;
        gap_cfg = 8'd5;
        ready   = 1'b1;
        enable  = 1'b1;
        tick();
        for (int n = 0; n < 188; n++) begin
            e = ref_byte(n, pid, 0);
            if (valid_out !== 1'b1 || ts_data_out !== e) errs++;
            if (n == 50) enable = 1'b0;
            if (n == 60) pid_cfg = 13'($urandom);
            tick();
        end
        for (int k = 0; k < 30; k++) begin
            if (valid_out !== 1'b0) vbad++;
            tick();
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL stop_bytes: got %0d bad beats want 0", errs); end
        total++; if (vbad !== 0) begin bad++; $display("FAIL stop_idle: got %0d valid cycles want 0", vbad); end
        total++; if (pkt_count !== 32'd1) begin bad++; $display("FAIL stop_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_reset_mid();
        int errs;
        logic [12:0] pid;
        errs = 0;
        do_reset();
        pid     = 13'($urandom);
        pid_cfg = pid;
        gap_cfg = 8'd0;
        ready   = 1'b1;
        enable  = 1'b1;
        tick();
        for (int i = 0; i < 288; i++) tick();
        total++; if (ts_data_out !== 8'd100 || pkt_count !== 32'd1) begin
            bad++; $display("FAIL midrst_pre: got data %0h count %0d want 64 and 1", ts_data_out, pkt_count);
        end
        rst = 1'b1;
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", valid_out); end
        total++; if (pkt_count !== 32'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", pkt_count); end
        rst = 1'b0;
        tick();
        for (int n = 0; n < 4; n++) begin
            if (valid_out !== 1'b1 || ts_data_out !== ref_byte(n, pid, 0)) errs++;
            tick();
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL midrst_restart: got %0d bad header beats want 0", errs); end
        enable = 1'b0;
    endtask

`ifdef TS_ERR_INJECT_EN
    task automatic test_err_inject();
        int n, p, want;
        do_reset();
        err_inject = 1'b0;
        pid_cfg    = 13'($urandom);
        gap_cfg    = 8'd0;
        ready      = 1'b1;
        enable     = 1'b1;
        tick();
        for (int i = 0; i < 6 * 188; i++) begin
            n = i % 188;
            p = i / 188;
            err_inject = (p == 3) && (n == 20 || n == 40);
            if (i == 5 * 188 + 10) enable = 1'b0;
            if (n == 3) begin
                want = (p < 4) ? p : p + 1;
                total++;
                if (ts_data_out !== {4'b0001, 4'(want)}) begin
                    bad++; $display("FAIL inject_cc pkt%0d: got %0h want %0h", p, ts_data_out, {4'b0001, 4'(want)});
                end
            end
            tick();
        end
        err_inject = 1'b0;
    endtask
`endif

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        ready   = 1'b0;
        pid_cfg = 13'd0;
        gap_cfg = 8'd0;
`ifdef TS_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        test_reset();
        test_basic();
        test_cc_wrap_random();
        test_ready_toggle();
        test_gap_stop();
        test_reset_mid();
`ifdef TS_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
